s526_misr_compactor: RTL and testbench

// - BIST response compactor placed directly downstream of the s526 benchmark core.
// - Each valid cycle it folds the core's six primary outputs into a WIDTH-bit MISR.
// - After NPAT samples it compares the signature to EXP_SIG and reports PASS/DONE.
// - Used for fault-coverage sign-off runs where per-cycle output compare is impractical.

---
 rtl/s526_bist_pkg.sv | 18 +
 rtl/misr_core.sv | 48 ++++
 rtl/s526_misr_compactor.sv | 150 +++++++++++++++
 tb/tb_s526_misr_compactor.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s526_bist_pkg.sv
// Shared types and constants for the s526 BIST response compactor.
// The default MISR polynomial and seed are defined here.
package s526_bist_pkg;

   localparam int RESP_W = 6;

   localparam logic [15:0] DEF_POLY = 16'h100B;
   localparam logic [15:0] DEF_SEED = 16'hFFFF;

   // ST_ prefix keeps the WARM state distinct from the WARM parameter of the top level.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WARM    = 2'd1,
      ST_COMPACT = 2'd2,
      ST_CHECK   = 2'd3
   } bist_state_e;

endpackage

// File: rtl/misr_core.sv
// Galois-feedback MISR register with seed load, compact enable and, under SIG_SHIFT_EN,
// a plain serial shift toward the MSB.
module misr_core
   import s526_bist_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
   parameter logic [WIDTH-1:0] SEED  = DEF_SEED
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              en_i,
`ifdef SIG_SHIFT_EN
   input  logic              shift_i,
`endif
   input  logic [RESP_W-1:0] data_i,
   output logic [WIDTH-1:0]  sig_o
);

   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (load_i) begin
         sig_d = SEED;
      end else if (en_i) begin
         sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ WIDTH'(data_i);
      end
`ifdef SIG_SHIFT_EN
      else if (shift_i) begin
         sig_d = {sig_q[WIDTH-2:0], 1'b0};
      end
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/s526_misr_compactor.sv
// BIST response compactor for the s526 core: warm-up discard, NPAT-sample MISR, signature compare.
// Optional serial signature unload enabled by defining SIG_SHIFT_EN.
module s526_misr_compactor
   import s526_bist_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] POLY  = DEF_POLY,
   parameter logic [WIDTH-1:0] SEED  = DEF_SEED,
   parameter int               CNT_W = 12,
   parameter int               WARM  = 2
) (
   input  logic              CK,
   input  logic              RN,
   input  logic              START,
   input  logic [CNT_W-1:0]  NPAT,
   input  logic [WIDTH-1:0]  EXP_SIG,
   input  logic [RESP_W-1:0] RESP,
   input  logic              RESP_VLD,
`ifdef SIG_SHIFT_EN
   input  logic              SHIFT,
   output logic              SO,
`endif
   output logic              BUSY,
   output logic              DONE,
   output logic              PASS,
   output logic [WIDTH-1:0]  SIG
);

   bist_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] warm_q, warm_d;
   logic [CNT_W-1:0] npat_q, npat_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic             misr_load;
   logic             misr_en;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] sig;

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      warm_d    = warm_q;
      npat_d    = npat_q;
      exp_d     = exp_q;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               misr_load = 1'b1;
               npat_d    = NPAT;
               exp_d     = EXP_SIG;
               cnt_d     = '0;
               warm_d    = CNT_W'(WARM);
               busy_d    = 1'b1;
               done_d    = 1'b0;
               pass_d    = 1'b0;
               // An empty run compares the seed itself, skipping warm-up entirely.
               if (NPAT == '0) begin
                  state_d = ST_CHECK;
               end else if (WARM > 0) begin
                  state_d = ST_WARM;
               end else begin
                  state_d = ST_COMPACT;
               end
            end
         end
         ST_WARM: begin
            if (RESP_VLD) begin
               warm_d = warm_q - CNT_W'(1);
               if (warm_q == CNT_W'(1)) begin
                  state_d = ST_COMPACT;
               end
            end
         end
         ST_COMPACT: begin
            if (RESP_VLD) begin
               misr_en = 1'b1;
               cnt_d   = cnt_inc;
               if (cnt_inc == npat_q) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            pass_d  = (sig == exp_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         warm_q  <= '0;
         npat_q  <= '0;
         exp_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         warm_q  <= warm_d;
         npat_q  <= npat_d;
         exp_q   <= exp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   misr_core #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk_i   (CK),
      .rst_ni  (RN),
      .load_i  (misr_load),
      .en_i    (misr_en),
`ifdef SIG_SHIFT_EN
      .shift_i (SHIFT && (state_q == ST_IDLE)),
`endif
      .data_i  (RESP),
      .sig_o   (sig)
   );

`ifdef SIG_SHIFT_EN
   assign SO = sig[WIDTH-1];
`endif

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign PASS = pass_q;
   assign SIG  = sig;

endmodule

// File: tb/tb_s526_misr_compactor.sv
// Directed bench for s526_misr_compactor: one instance with WARM=0, one with the default WARM=2.
module tb_s526_misr_compactor;

   logic        ck;
   logic        rn;
   logic        start0;
   logic        start2;
   logic [11:0] npat;
   logic [15:0] exp_sig;
   logic [5:0]  resp;
   logic        resp_vld;
   logic        busy0, done0, pass0;
   logic        busy2, done2, pass2;
   logic [15:0] sig0, sig2;
`ifdef SIG_SHIFT_EN
   logic        shift;
   logic        so0, so2;
`endif

   int checks   = 0;
   int failures = 0;

   s526_misr_compactor #(.WARM(0)) u_dut0 (
      .CK       (ck),
      .RN       (rn),
      .START    (start0),
      .NPAT     (npat),
      .EXP_SIG  (exp_sig),
      .RESP     (resp),
      .RESP_VLD (resp_vld),
`ifdef SIG_SHIFT_EN
      .SHIFT    (shift),
      .SO       (so0),
`endif
      .BUSY     (busy0),
      .DONE     (done0),
      .PASS     (pass0),
      .SIG      (sig0)
   );

   s526_misr_compactor u_dut2 (
      .CK       (ck),
      .RN       (rn),
      .START    (start2),
      .NPAT     (npat),
      .EXP_SIG  (exp_sig),
      .RESP     (resp),
      .RESP_VLD (resp_vld),
`ifdef SIG_SHIFT_EN
      .SHIFT    (shift),
      .SO       (so2),
`endif
      .BUSY     (busy2),
      .DONE     (done2),
      .PASS     (pass2),
      .SIG      (sig2)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic start_dut0(input logic [11:0] n, input logic [15:0] e);
      npat    = n;
      exp_sig = e;
      start0  = 1'b1;
      tick();
      start0  = 1'b0;
   endtask

   task automatic test_reset();
      rn = 1'b0;
      tick();
      checks++;
      if ({busy0, done0, pass0, sig0} !== 19'h0) begin
         failures++;
         $display("FAIL reset_dut0: busy=%b done=%b pass=%b sig=%h, required all zero", busy0, done0, pass0, sig0);
      end
      checks++;
      if ({busy2, done2, pass2, sig2} !== 19'h0) begin
         failures++;
         $display("FAIL reset_dut2: busy=%b done=%b pass=%b sig=%h, required all zero", busy2, done2, pass2, sig2);
      end
      rn = 1'b1;
      tick();
      $display("test_reset: sig0=%h sig2=%h", sig0, sig2);
   endtask

   // One-sample run on the WARM=0 instance; checks seed load, latency and compare.
   task automatic test_single(input logic [5:0] r, input logic [15:0] sig_exp, input logic pass_exp);
      start_dut0(12'd1, 16'hEFF5);
      checks++;
      if (busy0 !== 1'b1 || sig0 !== 16'hFFFF) begin
         failures++;
         $display("FAIL single_load: busy=%b sig=%h, required busy=1 sig=ffff", busy0, sig0);
      end
      resp     = r;
      resp_vld = 1'b1;
      tick();
      resp_vld = 1'b0;
      checks++;
      if (sig0 !== sig_exp || done0 !== 1'b0) begin
         failures++;
         $display("FAIL single_sample: sig=%h done=%b, required sig=%h done=0", sig0, done0, sig_exp);
      end
      tick();
      checks++;
      if (done0 !== 1'b1 || pass0 !== pass_exp || busy0 !== 1'b0 || sig0 !== sig_exp) begin
         failures++;
         $display("FAIL single_done: done=%b pass=%b busy=%b sig=%h, required done=1 pass=%b busy=0 sig=%h",
                  done0, pass0, busy0, sig0, pass_exp, sig_exp);
      end
      $display("test_single resp=%h: sig=%h done=%b pass=%b", r, sig0, done0, pass0);
   endtask

   task automatic test_warm();
      logic [5:0] vec [3];
      vec[0] = 6'h3F; vec[1] = 6'h3F; vec[2] = 6'h00;
      npat    = 12'd1;
      exp_sig = 16'hEFF5;
      start2  = 1'b1;
      tick();
      start2  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         resp     = vec[i];
         resp_vld = 1'b1;
         tick();
         if (i < 2) begin
            checks++;
            if (sig2 !== 16'hFFFF || busy2 !== 1'b1) begin
               failures++;
               $display("FAIL warm_discard%0d: sig=%h busy=%b, required sig=ffff busy=1", i, sig2, busy2);
            end
         end
      end
      resp_vld = 1'b0;
      checks++;
      if (sig2 !== 16'hEFF5 || done2 !== 1'b0) begin
         failures++;
         $display("FAIL warm_sample: sig=%h done=%b, required sig=eff5 done=0", sig2, done2);
      end
      tick();
      checks++;
      if (done2 !== 1'b1 || pass2 !== 1'b1) begin
         failures++;
         $display("FAIL warm_done: done=%b pass=%b, required done=1 pass=1", done2, pass2);
      end
      $display("test_warm: sig=%h done=%b pass=%b", sig2, done2, pass2);
   endtask

   // NPAT=3 with gaps; samples 01,02,03 give ffff->eff4->cfe1->8fca.
   task automatic test_gaps();
      logic       vld [6];
      logic [5:0] dat [6];
      vld[0] = 1; vld[1] = 0; vld[2] = 0; vld[3] = 1; vld[4] = 0; vld[5] = 1;
      dat[0] = 6'h01; dat[1] = 6'h3F; dat[2] = 6'h2A; dat[3] = 6'h02; dat[4] = 6'h15; dat[5] = 6'h03;
      start_dut0(12'd3, 16'h8FCA);
      for (int i = 0; i < 6; i++) begin
         resp     = dat[i];
         resp_vld = vld[i];
         tick();
         checks++;
         if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL gaps_busy%0d: busy=%b, required 1", i, busy0);
         end
      end
      resp_vld = 1'b0;
      checks++;
      if (sig0 !== 16'h8FCA || done0 !== 1'b0) begin
         failures++;
         $display("FAIL gaps_sig: sig=%h done=%b, required sig=8fca done=0", sig0, done0);
      end
      tick();
      checks++;
      if (done0 !== 1'b1 || pass0 !== 1'b1 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL gaps_done: done=%b pass=%b busy=%b, required 1 1 0", done0, pass0, busy0);
      end
      $display("test_gaps: sig=%h done=%b pass=%b", sig0, done0, pass0);
   endtask

   // Restart while DONE is high, with NPAT=0: seed is compared directly.
   task automatic test_npat_zero();
      start_dut0(12'd0, 16'hFFFF);
      checks++;
      if (done0 !== 1'b0 || pass0 !== 1'b0 || busy0 !== 1'b1 || sig0 !== 16'hFFFF) begin
         failures++;
         $display("FAIL npat0_start: done=%b pass=%b busy=%b sig=%h, required 0 0 1 ffff",
                  done0, pass0, busy0, sig0);
      end
      tick();
      checks++;
      if (done0 !== 1'b1 || pass0 !== 1'b1 || busy0 !== 1'b0) begin
         failures++;
         $display("FAIL npat0_done: done=%b pass=%b busy=%b, required 1 1 0", done0, pass0, busy0);
      end
      $display("test_npat_zero: sig=%h done=%b pass=%b", sig0, done0, pass0);
   endtask

   task automatic test_busy_start_and_abort();
      start_dut0(12'd3, 16'h0000);
      resp     = 6'h01;
      resp_vld = 1'b1;
      tick();
      resp_vld = 1'b0;
      start_dut0(12'd1, 16'h1234);
      checks++;
      if (sig0 !== 16'hEFF4 || busy0 !== 1'b1) begin
         failures++;
         $display("FAIL busy_start_ignored: sig=%h busy=%b, required sig=eff4 busy=1", sig0, busy0);
      end
      resp     = 6'h02;
      resp_vld = 1'b1;
      tick();
      resp_vld = 1'b0;
      tick();
      checks++;
      if (sig0 !== 16'hCFE1 || busy0 !== 1'b1 || done0 !== 1'b0) begin
         failures++;
         $display("FAIL busy_continue: sig=%h busy=%b done=%b, required sig=cfe1 busy=1 done=0",
                  sig0, busy0, done0);
      end
      #2;
      rn = 1'b0;
      #1;
      checks++;
      if ({busy0, done0, pass0, sig0} !== 19'h0) begin
         failures++;
         $display("FAIL abort: busy=%b done=%b pass=%b sig=%h, required all zero", busy0, done0, pass0, sig0);
      end
      tick();
      rn = 1'b1;
      tick();
      $display("test_busy_start_and_abort: sig=%h busy=%b", sig0, busy0);
   endtask

`ifdef SIG_SHIFT_EN
   task automatic test_shift();
      logic [15:0] expv;
      expv = 16'hEFF5;
      test_single(6'h00, 16'hEFF5, 1'b1);
      shift = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (so0 !== expv[15-i]) begin
            failures++;
            $display("FAIL shift_bit%0d: so=%b, required %b", i, so0, expv[15-i]);
         end
         tick();
      end
      shift = 1'b0;
      checks++;
      if (sig0 !== 16'h0000 || pass0 !== 1'b1 || done0 !== 1'b1) begin
         failures++;
         $display("FAIL shift_end: sig=%h pass=%b done=%b, required 0000 1 1", sig0, pass0, done0);
      end
      $display("test_shift: sig=%h pass=%b", sig0, pass0);
   endtask
`endif

   initial begin
      rn       = 1'b0;
      start0   = 1'b0;
      start2   = 1'b0;
      npat     = '0;
      exp_sig  = '0;
      resp     = '0;
      resp_vld = 1'b0;
`ifdef SIG_SHIFT_EN
      shift    = 1'b0;
`endif
      test_reset();
      test_single(6'h00, 16'hEFF5, 1'b1);
      test_single(6'h01, 16'hEFF4, 1'b0);
      test_warm();
      test_gaps();
      test_npat_zero();
      test_busy_start_and_abort();
`ifdef SIG_SHIFT_EN
      test_shift();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
